// File: rtl/serial_addsub_n_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The master drives the request and operands; the slave (datapath) drives results and status.
interface serial_addsub_n_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op_sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             busy;
    logic             done;

    modport master (
        output start, op_sub, a, b, ci,
        input  sum, co, ovf, busy, done
    );

    modport slave (
        input  start, op_sub, a, b, ci,
        output sum, co, ovf, busy, done
    );
endinterface

// File: rtl/serial_addsub_n.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock under a start/done handshake.
// Optional macro SERIAL_ADDSUB_ONES_CMP_EN: one's-complement subtract with an end-around-carry FIX pass.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start; operands latched on the accepting edge
// RUN    | main serial pass, one bit per clock for WIDTH clocks
// FIX    | end-around carry pass, adds 1 to the result (macro only)
// DONE   | one-cycle result-valid pulse, then back to IDLE
module serial_addsub_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_addsub_n_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
        ,
        S_FIX  = 2'd3
`endif
    } state_t;

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_ADDSUB_ONES_CMP_EN
    localparam logic SUB_C0 = 1'b0;
`else
    localparam logic SUB_C0 = 1'b1;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               co_q, co_d;
    logic               ovf_q, ovf_d;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
    logic               sub_q, sub_d;
`endif

    logic               s_bit;
    logic               c_nxt;
    logic               last_bit;
    logic [WIDTH-1:0]   sr_shift;

    assign s_bit    = sa_q[0] ^ sb_q[0] ^ c_q;
    assign c_nxt    = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
    assign last_bit = (idx_q == IDX_LAST);
    assign sr_shift = {s_bit, sr_q[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
            sub_q   <= sub_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.op_sub ? ~bus.b : bus.b;
                    c_d     = bus.op_sub ? SUB_C0 : bus.ci;
                    idx_d   = '0;
                    sr_d    = '0;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
                    sub_d   = bus.op_sub;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                c_d   = c_nxt;
                sr_d  = sr_shift;
                idx_d = idx_q + CNT_W'(1);
                if (last_bit) begin
                    co_d  = c_nxt;
                    ovf_d = c_q ^ c_nxt;
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
                    if (sub_q && c_nxt) begin
                        // End-around carry: re-run the result through the adder with B=0, C=1.
                        sa_d    = sr_shift;
                        sb_d    = '0;
                        c_d     = 1'b1;
                        idx_d   = '0;
                        sr_d    = '0;
                        state_d = S_FIX;
                    end else begin
                        sum_d   = sr_shift;
                        state_d = S_DONE;
                    end
`else
                    sum_d   = sr_shift;
                    state_d = S_DONE;
`endif
                end
            end
`ifdef SERIAL_ADDSUB_ONES_CMP_EN
            S_FIX: begin
                sa_d  = {1'b0, sa_q[WIDTH-1:1]};
                sb_d  = {1'b0, sb_q[WIDTH-1:1]};
                c_d   = c_nxt;
                sr_d  = sr_shift;
                idx_d = idx_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = sr_shift;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.sum  = sum_q;
    assign bus.co   = co_q;
    assign bus.ovf  = ovf_q;
    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);

endmodule
